// File: rtl/router_fsm.sv
// Router control FSM: address decode, payload load, FIFO-full stall and parity check per packet.
// Optional WAIT_TILL_EMPTY abort timer enabled by `define ROUTER_FSM_WAIT_TIMEOUT_EN.
module router_fsm #(
    parameter int unsigned WAIT_LIMIT = 30
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    output logic       busy,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       timeout_err
);
    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY_ERROR,
        WAIT_TILL_EMPTY
    } state_t;

    // Output vector order: {busy, detect_add, lfd, ld, laf, full, write_enb, rst_int}
    localparam int unsigned OUT_W = 8;
    localparam logic [OUT_W-1:0] OUT_DEC  = 8'h40;
    localparam logic [OUT_W-1:0] OUT_LFD  = 8'hA0;
    localparam logic [OUT_W-1:0] OUT_LD   = 8'h12;
    localparam logic [OUT_W-1:0] OUT_FULL = 8'h84;
    localparam logic [OUT_W-1:0] OUT_LAF  = 8'h8A;
    localparam logic [OUT_W-1:0] OUT_LP   = 8'h82;
    localparam logic [OUT_W-1:0] OUT_CPE  = 8'h81;
    localparam logic [OUT_W-1:0] OUT_WAIT = 8'h80;

    state_t           state;
    state_t           next_state;
    logic [1:0]       addr_reg;
    logic [3:0]       empty_vec;
    logic [3:0]       srst_vec;
    logic             sel_empty;
    logic             sel_srst;
    logic             limit_hit;
    logic [OUT_W-1:0] outs_q;
    logic [OUT_W-1:0] outs_nx;

    assign empty_vec = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign srst_vec  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
    assign sel_empty = empty_vec[addr_reg];
    assign sel_srst  = srst_vec[addr_reg];

    // State, latched destination and registered Moore outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= DECODE_ADDRESS;
            addr_reg <= 2'd0;
            outs_q   <= OUT_DEC;
        end else begin
            state  <= next_state;
            outs_q <= outs_nx;
            if (state == DECODE_ADDRESS && next_state != DECODE_ADDRESS) begin
                addr_reg <= data_in;
            end
        end
    end

    always_comb begin
        next_state = state;
        outs_nx    = '0;
        if (state != DECODE_ADDRESS && sel_srst) begin
            next_state = DECODE_ADDRESS;
        end else begin
            case (state)
                DECODE_ADDRESS: begin
                    if (pkt_valid && data_in != 2'd3) begin
                        next_state = empty_vec[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
                LOAD_FIRST_DATA: next_state = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full)       next_state = FIFO_FULL_STATE;
                    else if (!pkt_valid) next_state = LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full) next_state = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done)        next_state = DECODE_ADDRESS;
                    else if (low_pkt_valid) next_state = LOAD_PARITY;
                    else                    next_state = LOAD_DATA;
                end
                LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                WAIT_TILL_EMPTY: begin
                    if (sel_empty)      next_state = LOAD_FIRST_DATA;
                    else if (limit_hit) next_state = DECODE_ADDRESS;
                end
                default: next_state = DECODE_ADDRESS;
            endcase
        end
        case (next_state)
            DECODE_ADDRESS:     outs_nx = OUT_DEC;
            LOAD_FIRST_DATA:    outs_nx = OUT_LFD;
            LOAD_DATA:          outs_nx = OUT_LD;
            FIFO_FULL_STATE:    outs_nx = OUT_FULL;
            LOAD_AFTER_FULL:    outs_nx = OUT_LAF;
            LOAD_PARITY:        outs_nx = OUT_LP;
            CHECK_PARITY_ERROR: outs_nx = OUT_CPE;
            WAIT_TILL_EMPTY:    outs_nx = OUT_WAIT;
            default:            outs_nx = OUT_DEC;
        endcase
    end

    assign {busy, detect_add, lfd_state, ld_state, laf_state, full_state,
            write_enb_reg, rst_int_reg} = outs_q;

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(WAIT_LIMIT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             abort_c;
    logic             timeout_q;

    // wait_cnt holds completed wait cycles; zero whenever outside WAIT_TILL_EMPTY
    assign limit_hit = (wait_cnt == CNT_W'(WAIT_LIMIT - 1));
    assign abort_c   = (state == WAIT_TILL_EMPTY) && !sel_srst && !sel_empty && limit_hit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_cnt  <= (state == WAIT_TILL_EMPTY) ? wait_cnt + CNT_W'(1) : '0;
            timeout_q <= abort_c;
        end
    end

    assign timeout_err = timeout_q;
`else
    logic unused_limit;

    assign limit_hit    = 1'b0;
    assign timeout_err  = 1'b0;
    assign unused_limit = (WAIT_LIMIT == 32'd0);
`endif

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural packet-flow model.
module tb_router_fsm;
    localparam int unsigned WAIT_LIMIT = 30;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk, rstn;
    logic       pkt_valid, parity_done, low_pkt_valid, fifo_full;
    logic [1:0] data_in;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       busy, detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, timeout_err;

    int tests = 0;
    int fails = 0;

    router_fsm #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk(clk), .rstn(rstn), .pkt_valid(pkt_valid), .data_in(data_in),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
        .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
        .busy(busy), .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
        .rst_int_reg(rst_int_reg), .timeout_err(timeout_err)
    );

    logic [7:0] outs;
    assign outs = {busy, detect_add, lfd_state, ld_state, laf_state, full_state,
                   write_enb_reg, rst_int_reg};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: packet phase, destination and time spent waiting
    typedef enum int {P_DEC, P_LFD, P_LD, P_FULL, P_LAF, P_LP, P_CPE, P_WAIT} phase_t;
    phase_t     m_phase = P_DEC;
    logic [1:0] m_addr  = 2'd0;
    int         m_waited = 0;
    bit         m_to = 1'b0;
    logic [7:0] m_flags [8] = '{8'h40, 8'hA0, 8'h12, 8'h84, 8'h8A, 8'h82, 8'hC1 & 8'h81, 8'h80};

    task automatic model_reset();
        m_phase  = P_DEC;
        m_addr   = 2'd0;
        m_waited = 0;
        m_to     = 1'b0;
    endtask

    task automatic model_step();
        bit [3:0] emp;
        bit [3:0] srs;
        phase_t   nxt;
        bit       to;
        emp = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
        srs = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
        nxt = m_phase;
        to  = 1'b0;
        if (m_phase != P_DEC && srs[m_addr]) begin
            nxt = P_DEC;
        end else begin
            case (m_phase)
                P_DEC: if (pkt_valid && data_in != 2'd3) begin
                    m_addr = data_in;
                    nxt = emp[data_in] ? P_LFD : P_WAIT;
                end
                P_LFD:  nxt = P_LD;
                P_LD:   nxt = fifo_full ? P_FULL : (!pkt_valid ? P_LP : P_LD);
                P_FULL: nxt = fifo_full ? P_FULL : P_LAF;
                P_LAF:  nxt = parity_done ? P_DEC : (low_pkt_valid ? P_LP : P_LD);
                P_LP:   nxt = P_CPE;
                P_CPE:  nxt = fifo_full ? P_FULL : P_DEC;
                P_WAIT: begin
                    m_waited++;
                    if (emp[m_addr]) nxt = P_LFD;
                    else if (TO_EN && m_waited == int'(WAIT_LIMIT)) begin
                        nxt = P_DEC;
                        to  = 1'b1;
                    end
                end
                default: nxt = P_DEC;
            endcase
        end
        if (nxt == P_WAIT && m_phase != P_WAIT) m_waited = 0;
        m_phase = nxt;
        m_to    = to;
    endtask

    always @(negedge rstn) model_reset();

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        if (!rstn) model_reset();
        else       model_step();
        #1;
        tests++;
        if (outs !== m_flags[int'(m_phase)] || timeout_err !== m_to) begin
            fails++;
            $display("FAIL model_cmp t=%0t got flags=%h to=%b exp flags=%h to=%b",
                     $time, outs, timeout_err, m_flags[int'(m_phase)], m_to);
        end
    end

    task automatic check_lit(input string nm, input logic [7:0] exp, input logic exp_to);
        tests++;
        if (outs !== exp || timeout_err !== exp_to) begin
            fails++;
            $display("FAIL %s t=%0t got flags=%h to=%b exp flags=%h to=%b",
                     nm, $time, outs, timeout_err, exp, exp_to);
        end
    endtask

    task automatic step_chk(input string nm, input logic [7:0] exp);
        @(posedge clk);
        #2;
        check_lit(nm, exp, 1'b0);
    endtask

    task automatic idle_inputs();
        pkt_valid = 0; data_in = 0; parity_done = 0; low_pkt_valid = 0; fifo_full = 0;
        fifo_empty_0 = 0; fifo_empty_1 = 0; fifo_empty_2 = 0;
        soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
    endtask

    initial begin
        rstn = 1'b1;
        idle_inputs();
        #1 rstn = 1'b0;
        #1 check_lit("reset_outputs", 8'h40, 1'b0);
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;

        // Header to first data to payload
        pkt_valid = 1; data_in = 0; fifo_empty_0 = 1;
        step_chk("first_data", 8'hA0);
        step_chk("load_data", 8'h12);
        step_chk("load_data_hold", 8'h12);
        // Packet end through parity check
        pkt_valid = 0;
        step_chk("load_parity", 8'h82);
        step_chk("check_parity", 8'h81);
        step_chk("back_to_decode", 8'h40);

        // FIFO full stall for three cycles, then load-after-full
        pkt_valid = 1;
        step_chk("lfd_2", 8'hA0);
        step_chk("ld_2", 8'h12);
        fifo_full = 1;
        for (int i = 0; i < 3; i++) step_chk("full_stall", 8'h84);
        fifo_full = 0; low_pkt_valid = 1;
        step_chk("load_after_full", 8'h8A);
        step_chk("laf_to_parity", 8'h82);
        low_pkt_valid = 0; pkt_valid = 0;
        step_chk("check_parity_2", 8'h81);
        step_chk("decode_2", 8'h40);

        // Busy destination, foreign soft reset ignored
        pkt_valid = 1; data_in = 1; fifo_empty_1 = 0;
        step_chk("wait_empty", 8'h80);
        soft_reset_0 = 1;
        step_chk("wait_ignores_srst0", 8'h80);
        fifo_empty_1 = 1;
        step_chk("wait_to_lfd", 8'hA0);
        soft_reset_0 = 0;
        step_chk("ld_addr1", 8'h12);
        soft_reset_1 = 1;
        step_chk("srst1_abort", 8'h40);
        soft_reset_1 = 0;

        // Selected soft reset beats fifo_full; address 3 is never accepted
        data_in = 2; fifo_empty_2 = 1;
        step_chk("lfd_addr2", 8'hA0);
        step_chk("ld_addr2", 8'h12);
        fifo_full = 1; soft_reset_2 = 1;
        step_chk("srst2_beats_full", 8'h40);
        fifo_full = 0; soft_reset_2 = 0; data_in = 3;
        step_chk("addr3_stays", 8'h40);
        step_chk("addr3_stays_2", 8'h40);

        // Reset mid-packet abandons it
        data_in = 0;
        step_chk("lfd_pre_rst", 8'hA0);
        step_chk("ld_pre_rst", 8'h12);
        rstn = 0;
        #1 check_lit("async_reset", 8'h40, 1'b0);
        step_chk("held_reset", 8'h40);
        pkt_valid = 0; rstn = 1;
        step_chk("post_reset_idle", 8'h40);

        // Destination never drains
        pkt_valid = 1; data_in = 0; fifo_empty_0 = 0;
        step_chk("wait_long_entry", 8'h80);
        pkt_valid = 0;
        if (TO_EN) begin
            for (int i = 1; i < int'(WAIT_LIMIT); i++) step_chk("wait_before_limit", 8'h80);
            @(posedge clk);
            #2 check_lit("timeout_abort", 8'h40, 1'b1);
            step_chk("timeout_single_pulse", 8'h40);
        end else begin
            repeat (98) @(posedge clk);
            step_chk("still_waiting_100", 8'h80);
            rstn = 0;
            step_chk("reset_from_wait", 8'h40);
            rstn = 1;
        end

        // Randomized traffic, checked by the model every cycle
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk);
            #2;
            pkt_valid     = ($urandom_range(0, 7) != 0);
            data_in       = 2'($urandom_range(0, 3));
            fifo_full     = ($urandom_range(0, 3) == 0);
            parity_done   = ($urandom_range(0, 3) == 0);
            low_pkt_valid = ($urandom_range(0, 3) == 0);
            fifo_empty_0  = ($urandom_range(0, 2) == 0);
            fifo_empty_1  = ($urandom_range(0, 2) == 0);
            fifo_empty_2  = ($urandom_range(0, 2) == 0);
            soft_reset_0  = ($urandom_range(0, 24) == 0);
            soft_reset_1  = ($urandom_range(0, 24) == 0);
            soft_reset_2  = ($urandom_range(0, 24) == 0);
            rstn          = ($urandom_range(0, 299) != 0);
        end
        @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
